// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU execute-stage sequencer: ALU control codes,
// opcode/funct encodings, FSM state type and the decode record.
package alu_seq_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;

    typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;

    // Second ALU operand source and how the 16-bit immediate is widened.
    typedef enum logic {B_RT, B_IMM} bsel_t;
    typedef enum logic {EXT_ZERO, EXT_SIGN} ext_t;

    typedef struct packed {
        logic [3:0] alu_ctrl;
        bsel_t      b_sel;
        ext_t       ext;
        logic       we;
        logic       is_branch;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational opcode/funct decoder for the ALU sequencer.
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output dec_t       dec
);

    // Map the instruction fields onto ALU op, operand-B source and writeback flags.
    always_comb begin
        dec = '{alu_ctrl: ALU_AND, b_sel: B_RT, ext: EXT_ZERO,
                we: 1'b0, is_branch: 1'b0, illegal: 1'b1};
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin dec.alu_ctrl = ALU_ADD; dec.we = 1'b1; dec.illegal = 1'b0; end
                    FN_SUB: begin dec.alu_ctrl = ALU_SUB; dec.we = 1'b1; dec.illegal = 1'b0; end
                    FN_AND: begin dec.alu_ctrl = ALU_AND; dec.we = 1'b1; dec.illegal = 1'b0; end
                    FN_OR:  begin dec.alu_ctrl = ALU_OR;  dec.we = 1'b1; dec.illegal = 1'b0; end
                    default: ;
                endcase
            end
            OP_ADDI: begin
                dec.alu_ctrl = ALU_ADD;
                dec.b_sel    = B_IMM;
                dec.ext      = EXT_SIGN;
                dec.we       = 1'b1;
                dec.illegal  = 1'b0;
            end
            OP_ANDI: begin
                dec.alu_ctrl = ALU_AND;
                dec.b_sel    = B_IMM;
                dec.we       = 1'b1;
                dec.illegal  = 1'b0;
            end
            OP_ORI: begin
                dec.alu_ctrl = ALU_OR;
                dec.b_sel    = B_IMM;
                dec.we       = 1'b1;
                dec.illegal  = 1'b0;
            end
            OP_BEQ: begin
                dec.alu_ctrl  = ALU_SUB;
                dec.is_branch = 1'b1;
                dec.illegal   = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multicycle execute-stage controller: accepts one decoded instruction, drives
// registered ALU operands/control, waits ALU_LATENCY cycles, captures the result
// and presents a writeback record. Optional macro ALU_SEQ_LOCAL_ZERO_EN derives
// the zero flag from ALU_result instead of the zero input.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ALU_LATENCY = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_opcode,
    input  logic [5:0]        in_funct,
    input  logic [DATA_W-1:0] in_rs_data,
    input  logic [DATA_W-1:0] in_rt_data,
    input  logic [15:0]       in_imm,
    input  logic [4:0]        in_dest,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] Mux,
    output logic [3:0]        ALU_control,
    input  logic [DATA_W-1:0] ALU_result,
    input  logic              zero,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [4:0]        wb_dest,
    output logic              wb_we,
    output logic              wb_branch_taken,
    output logic              wb_illegal
);

    localparam int CNT_W = (ALU_LATENCY > 0) ? $clog2(ALU_LATENCY + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LATENCY);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             we_q;
    logic             branch_q;
    dec_t             dec;
    logic             zero_eff;

    function automatic logic [DATA_W-1:0] extend_imm(input logic [15:0] imm, input ext_t ext);
        logic signed [DATA_W-1:0] sext;
        sext = DATA_W'(signed'(imm));
        return (ext == EXT_SIGN) ? DATA_W'(sext) : DATA_W'(imm);
    endfunction

    alu_seq_decode u_decode (
        .opcode (in_opcode),
        .funct  (in_funct),
        .dec    (dec)
    );

`ifdef ALU_SEQ_LOCAL_ZERO_EN
    assign zero_eff = (ALU_result == '0);
`else
    assign zero_eff = zero;
`endif

    // Control FSM with registered ALU-side and writeback-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            in_ready        <= 1'b1;
            read_data1      <= '0;
            Mux             <= '0;
            ALU_control     <= ALU_AND;
            wb_valid        <= 1'b0;
            wb_data         <= '0;
            wb_dest         <= '0;
            wb_we           <= 1'b0;
            wb_branch_taken <= 1'b0;
            wb_illegal      <= 1'b0;
            we_q            <= 1'b0;
            branch_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        wb_dest  <= in_dest;
                        if (dec.illegal) begin
                            // Skip the ALU entirely; its outputs keep the last issue.
                            wb_valid        <= 1'b1;
                            wb_data         <= '0;
                            wb_we           <= 1'b0;
                            wb_branch_taken <= 1'b0;
                            wb_illegal      <= 1'b1;
                            state           <= WB;
                        end else begin
                            read_data1  <= in_rs_data;
                            Mux         <= (dec.b_sel == B_IMM) ? extend_imm(in_imm, dec.ext)
                                                                : in_rt_data;
                            ALU_control <= dec.alu_ctrl;
                            we_q        <= dec.we;
                            branch_q    <= dec.is_branch;
                            cnt         <= CNT_LOAD;
                            state       <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (cnt == '0) begin
                        wb_valid        <= 1'b1;
                        wb_data         <= ALU_result;
                        wb_we           <= we_q;
                        wb_branch_taken <= branch_q & zero_eff;
                        wb_illegal      <= 1'b0;
                        state           <= WB;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WB: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a table of single instructions on a
// zero-latency instance, plus stall and reset sequences on a two-cycle instance.
module tb_alu_sequencer;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference ALU behaviour.
    function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0000: return a & b;
            4'b0001: return a | b;
            default: return 32'h0;
        endcase
    endfunction

    // ---------------- instance A: ALU_LATENCY = 0 ----------------
    logic        a_reset, a_in_valid, a_in_ready, a_zero;
    logic [5:0]  a_opcode, a_funct;
    logic [31:0] a_rs, a_rt, a_rd1, a_mux, a_res, a_wb_data;
    logic [15:0] a_imm;
    logic [4:0]  a_dest, a_wb_dest;
    logic [3:0]  a_ctrl;
    logic        a_wb_valid, a_wb_ready, a_wb_we, a_wb_br, a_wb_ill;

    assign a_res = alu_f(a_ctrl, a_rd1, a_mux);
`ifdef ALU_SEQ_LOCAL_ZERO_EN
    assign a_zero = 1'b0;
`else
    assign a_zero = (a_res == 32'h0);
`endif

    alu_sequencer #(.DATA_W(32), .ALU_LATENCY(0)) dut_a (
        .clk(clk), .reset(a_reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_opcode(a_opcode), .in_funct(a_funct), .in_rs_data(a_rs), .in_rt_data(a_rt),
        .in_imm(a_imm), .in_dest(a_dest), .read_data1(a_rd1), .Mux(a_mux),
        .ALU_control(a_ctrl), .ALU_result(a_res), .zero(a_zero), .wb_valid(a_wb_valid),
        .wb_ready(a_wb_ready), .wb_data(a_wb_data), .wb_dest(a_wb_dest), .wb_we(a_wb_we),
        .wb_branch_taken(a_wb_br), .wb_illegal(a_wb_ill)
    );

    // ---------------- instance B: ALU_LATENCY = 2 ----------------
    logic        b_reset, b_in_valid, b_in_ready, b_zero;
    logic [5:0]  b_opcode, b_funct;
    logic [31:0] b_rs, b_rt, b_rd1, b_mux, b_res, b_wb_data, b_d1;
    logic [15:0] b_imm;
    logic [4:0]  b_dest, b_wb_dest;
    logic [3:0]  b_ctrl;
    logic        b_wb_valid, b_wb_ready, b_wb_we, b_wb_br, b_wb_ill;

    // Two-stage pipelined ALU model: result reflects operands from two cycles ago.
    always @(posedge clk) begin
        b_d1  <= alu_f(b_ctrl, b_rd1, b_mux);
        b_res <= b_d1;
    end
    assign b_zero = (b_res == 32'h0);

    alu_sequencer #(.DATA_W(32), .ALU_LATENCY(2)) dut_b (
        .clk(clk), .reset(b_reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_opcode(b_opcode), .in_funct(b_funct), .in_rs_data(b_rs), .in_rt_data(b_rt),
        .in_imm(b_imm), .in_dest(b_dest), .read_data1(b_rd1), .Mux(b_mux),
        .ALU_control(b_ctrl), .ALU_result(b_res), .zero(b_zero), .wb_valid(b_wb_valid),
        .wb_ready(b_wb_ready), .wb_data(b_wb_data), .wb_dest(b_wb_dest), .wb_we(b_wb_we),
        .wb_branch_taken(b_wb_br), .wb_illegal(b_wb_ill)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] imm;
        logic [4:0]  dest;
        logic [3:0]  e_ctrl;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic [31:0] e_data;
        logic        e_we;
        logic        e_br;
        logic        e_ill;
    } vec_t;

    vec_t vecs[12];

    initial begin
        //            op     fn     rs            rt          imm       dest  ctrl     A             B             data          we    br    ill
        vecs[0]  = '{6'h00, 6'h20, 32'd5,        32'd7,      16'h0000, 5'd3,  4'b0010, 32'd5,        32'd7,        32'd12,       1'b1, 1'b0, 1'b0};
        vecs[1]  = '{6'h08, 6'h00, 32'd10,       32'd0,      16'hFFFF, 5'd4,  4'b0010, 32'd10,       32'hFFFFFFFF, 32'd9,        1'b1, 1'b0, 1'b0};
        vecs[2]  = '{6'h0D, 6'h00, 32'h1,        32'h0,      16'h8000, 5'd5,  4'b0001, 32'h1,        32'h00008000, 32'h00008001, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{6'h04, 6'h00, 32'h1234,     32'h1234,   16'h0000, 5'd6,  4'b0110, 32'h1234,     32'h1234,     32'h0,        1'b0, 1'b1, 1'b0};
        vecs[4]  = '{6'h04, 6'h00, 32'd5,        32'd6,      16'h0000, 5'd7,  4'b0110, 32'd5,        32'd6,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{6'h00, 6'h22, 32'd100,      32'd1,      16'h0000, 5'd8,  4'b0110, 32'd100,      32'd1,        32'd99,       1'b1, 1'b0, 1'b0};
        vecs[6]  = '{6'h00, 6'h24, 32'hF0F0,     32'hFF00,   16'h0000, 5'd9,  4'b0000, 32'hF0F0,     32'hFF00,     32'hF000,     1'b1, 1'b0, 1'b0};
        vecs[7]  = '{6'h00, 6'h25, 32'h0F,       32'hF0,     16'h0000, 5'd10, 4'b0001, 32'h0F,       32'hF0,       32'hFF,       1'b1, 1'b0, 1'b0};
        vecs[8]  = '{6'h3F, 6'h00, 32'hAAAA,     32'hBBBB,   16'h1234, 5'd11, 4'b0001, 32'h0F,       32'hF0,       32'h0,        1'b0, 1'b0, 1'b1};
        vecs[9]  = '{6'h00, 6'h21, 32'h1,        32'h2,      16'h0000, 5'd12, 4'b0001, 32'h0F,       32'hF0,       32'h0,        1'b0, 1'b0, 1'b1};
        vecs[10] = '{6'h08, 6'h00, 32'd3,        32'd0,      16'h7FFF, 5'd13, 4'b0010, 32'd3,        32'h00007FFF, 32'h00008002, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{6'h0C, 6'h00, 32'hFFFFFFFF, 32'h0,      16'h8001, 5'd14, 4'b0000, 32'hFFFFFFFF, 32'h00008001, 32'h00008001, 1'b1, 1'b0, 1'b0};

        a_reset = 1'b1; a_in_valid = 1'b0; a_wb_ready = 1'b1;
        a_opcode = '0; a_funct = '0; a_rs = '0; a_rt = '0; a_imm = '0; a_dest = '0;
        b_reset = 1'b1; b_in_valid = 1'b0; b_wb_ready = 1'b0;
        b_opcode = '0; b_funct = '0; b_rs = '0; b_rt = '0; b_imm = '0; b_dest = '0;
        repeat (3) step();
        a_reset = 1'b0;
        b_reset = 1'b0;
        step();

        // Reset state
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_wb_valid", a_wb_valid, 0);
        chk("rst_wb_we", a_wb_we, 0);
        chk("rst_wb_br", a_wb_br, 0);
        chk("rst_wb_ill", a_wb_ill, 0);
        chk("rst_wb_data", a_wb_data, 0);
        chk("rst_wb_dest", a_wb_dest, 0);
        chk("rst_rd1", a_rd1, 0);
        chk("rst_mux", a_mux, 0);
        chk("rst_ctrl", a_ctrl, 0);

        // Table-driven single instructions, latency 0, wb_ready held high
        for (int i = 0; i < 12; i++) begin
            int n;
            n = 0;
            while (!a_in_ready && n < 20) begin
                step();
                n++;
            end
            chk("a_ready_wait", a_in_ready, 1);
            a_in_valid = 1'b1;
            a_opcode = vecs[i].op; a_funct = vecs[i].fn;
            a_rs = vecs[i].rs; a_rt = vecs[i].rt; a_imm = vecs[i].imm; a_dest = vecs[i].dest;
            step();
            a_in_valid = 1'b0;
            if (!vecs[i].e_ill) begin
                chk($sformatf("v%0d_issue_ready", i), a_in_ready, 0);
                chk($sformatf("v%0d_issue_wbv", i), a_wb_valid, 0);
                chk($sformatf("v%0d_issue_ctrl", i), a_ctrl, vecs[i].e_ctrl);
                chk($sformatf("v%0d_issue_a", i), a_rd1, vecs[i].e_a);
                chk($sformatf("v%0d_issue_b", i), a_mux, vecs[i].e_b);
                step();
            end
            chk($sformatf("v%0d_wb_valid", i), a_wb_valid, 1);
            chk($sformatf("v%0d_wb_data", i), a_wb_data, vecs[i].e_data);
            chk($sformatf("v%0d_wb_we", i), a_wb_we, vecs[i].e_we);
            chk($sformatf("v%0d_wb_br", i), a_wb_br, vecs[i].e_br);
            chk($sformatf("v%0d_wb_ill", i), a_wb_ill, vecs[i].e_ill);
            chk($sformatf("v%0d_wb_dest", i), a_wb_dest, vecs[i].dest);
            chk($sformatf("v%0d_wb_ctrl", i), a_ctrl, vecs[i].e_ctrl);
            chk($sformatf("v%0d_wb_a", i), a_rd1, vecs[i].e_a);
            chk($sformatf("v%0d_wb_b", i), a_mux, vecs[i].e_b);
            chk($sformatf("v%0d_wb_ready", i), a_in_ready, 0);
            step();
            chk($sformatf("v%0d_back_ready", i), a_in_ready, 1);
            chk($sformatf("v%0d_back_wbv", i), a_wb_valid, 0);
        end

        // Latency 2 with downstream stall: sub 50-8
        b_in_valid = 1'b1; b_opcode = 6'h00; b_funct = 6'h22;
        b_rs = 32'd50; b_rt = 32'd8; b_imm = '0; b_dest = 5'd17;
        chk("b_ready_n", b_in_ready, 1);
        step();                                   // N+1
        b_in_valid = 1'b0;
        chk("b_n1_ready", b_in_ready, 0);
        chk("b_n1_wbv", b_wb_valid, 0);
        chk("b_n1_ctrl", b_ctrl, 4'b0110);
        step();                                   // N+2
        chk("b_n2_wbv", b_wb_valid, 0);
        step();                                   // N+3
        chk("b_n3_wbv", b_wb_valid, 0);
        step();                                   // N+4
        chk("b_n4_wbv", b_wb_valid, 1);
        chk("b_n4_data", b_wb_data, 32'd42);
        chk("b_n4_we", b_wb_we, 1);
        chk("b_n4_dest", b_wb_dest, 17);
        for (int k = 5; k <= 8; k++) begin
            step();                               // N+5 .. N+8
            chk($sformatf("b_n%0d_wbv", k), b_wb_valid, 1);
            chk($sformatf("b_n%0d_data", k), b_wb_data, 32'd42);
            chk($sformatf("b_n%0d_we", k), b_wb_we, 1);
            chk($sformatf("b_n%0d_br", k), b_wb_br, 0);
            chk($sformatf("b_n%0d_dest", k), b_wb_dest, 17);
            chk($sformatf("b_n%0d_ready", k), b_in_ready, 0);
        end
        b_wb_ready = 1'b1;                        // handshake at end of N+8
        step();                                   // N+9
        chk("b_n9_ready", b_in_ready, 1);
        chk("b_n9_wbv", b_wb_valid, 0);

        // Reset asserted while in ISSUE abandons the transaction
        b_in_valid = 1'b1; b_opcode = 6'h00; b_funct = 6'h20;
        b_rs = 32'd1; b_rt = 32'd2; b_dest = 5'd9;
        step();                                   // ISSUE
        b_in_valid = 1'b0;
        chk("r_issue_ready", b_in_ready, 0);
        chk("r_issue_ctrl", b_ctrl, 4'b0010);
        b_reset = 1'b1;
        step();
        b_reset = 1'b0;
        chk("r_after_ready", b_in_ready, 1);
        chk("r_after_rd1", b_rd1, 0);
        chk("r_after_ctrl", b_ctrl, 0);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("r_nowb_%0d", k), b_wb_valid, 0);
            step();
        end
        chk("r_idle_ready", b_in_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
